// File: rtl/memory_unit_32.sv
// memory_unit_32: word-addressed synchronous RAM behind the datapath memory
// port. A request is latched in IDLE and held for WAIT_STATES extra cycles in
// BUSY. The access is then performed, and completion is flagged for one cycle
// in DONE.
module memory_unit_32 #(
   parameter int ADDR_BITS   = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        in_clr_n,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_read,
   input  logic        in_write,
   output logic [31:0] out_rdata,
   output logic        out_busy,
   output logic        out_done,
   output logic        out_err
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
   } req_t;

   state_t         state_q, state_d;
   req_t           req_q, req_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   logic [31:0]    mem [DEPTH];

   logic [ADDR_BITS-1:0] idx;
   logic           oor;
   logic           conflict;
   logic           access;
   logic           mem_we;

   // Decode the latched request. Only latched values feed the access.
   assign idx      = req_q.addr[ADDR_BITS-1:0];
   assign oor      = |(req_q.addr >> ADDR_BITS);
   assign conflict = req_q.rd & req_q.wr;
   assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
   // Errors never modify the array. The state is forced to IDLE by reset,
   // so a pending write cannot commit.
   assign mem_we   = access & req_q.wr & ~req_q.rd & ~oor;

   // Next-state, request latch, wait counter and read-data update.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_read | in_write) begin
               req_d.addr  = in_addr;
               req_d.wdata = in_wdata;
               req_d.rd    = in_read;
               req_d.wr    = in_write;
               cnt_d       = 4'(WAIT_STATES);
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = 4'(cnt_q - 4'd1);
            end else begin
               state_d = DONE;
               err_d   = oor | conflict;
               // A conflicting request leaves the read data untouched.
               if (req_q.rd && !conflict) rdata_d = oor ? 32'd0 : mem[idx];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers, cleared asynchronously. The RAM array is not cleared.
   always_ff @(posedge clk or negedge in_clr_n) begin
      if (!in_clr_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= req_q.wdata;
   end

   assign out_rdata = rdata_q;
   assign out_busy  = (state_q == BUSY);
   assign out_done  = (state_q == DONE);
   assign out_err   = (state_q == DONE) & err_q;

endmodule
